// File: rtl/timeout_timer.sv
// timeout_timer: counts 1 s strobes and emits a one-cycle timeout pulse after a
// programmable number of them. Supports one-shot/periodic, pause, abort, restart
// and a saturating expiry counter.
//
// state | meaning
// IDLE  | not counting; remaining is 0, ticks ignored
// RUN   | counting accepted ticks down towards expiry
// HOLD  | counting suspended by pause; remaining frozen
module timeout_timer #(
  parameter int CNT_W       = 4,
  parameter int DEFAULT_LEN = 2,
  parameter int EXP_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [CNT_W-1:0] len,
  output logic             timeout,
  output logic             busy,
  output logic             paused,
  output logic [CNT_W-1:0] remaining,
  output logic [EXP_W-1:0] expiries
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEF_LEN = CNT_W'(DEFAULT_LEN);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             mode_q, mode_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic             to_q, to_d;
  logic             busy_q, paused_q;

  // State and output registers; busy/paused are registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      len_q    <= '0;
      mode_q   <= 1'b0;
      exp_q    <= '0;
      to_q     <= 1'b0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
      exp_q    <= exp_d;
      to_q     <= to_d;
      busy_q   <= (state_d != IDLE);
      paused_q <= (state_d == HOLD);
    end
  end

  // Next-state logic: stop beats start, start beats tick/pause handling
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    len_d   = len_q;
    mode_d  = mode_q;
    exp_d   = exp_q;
    to_d    = 1'b0;
    if (stop) begin
      state_d = IDLE;
      rem_d   = '0;
    end else if (start) begin
      len_d   = (len == '0) ? DEF_LEN : len;
      mode_d  = mode;
      rem_d   = (len == '0) ? DEF_LEN : len;
      exp_d   = '0;
      state_d = pause ? HOLD : RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (pause) begin
            state_d = HOLD;
          end else if (tick_in) begin
            if (rem_q > ONE) begin
              rem_d = rem_q - ONE;
            end else begin
              to_d  = 1'b1;
              exp_d = (exp_q == '1) ? exp_q : exp_q + 1'b1;
              if (mode_q) begin
                rem_d = len_q;
              end else begin
                rem_d   = '0;
                state_d = IDLE;
              end
            end
          end
        end
        HOLD: begin
          if (!pause) state_d = RUN;
        end
        default: ;
      endcase
    end
  end

  assign timeout   = to_q;
  assign busy      = busy_q;
  assign paused    = paused_q;
  assign remaining = rem_q;
  assign expiries  = exp_q;

endmodule

// File: tb/tb_timeout_timer.sv
// Directed bench for timeout_timer: main instance with default parameters and a
// second instance with a 2-bit expiry counter for saturation, sharing stimulus.
module tb_timeout_timer;

  logic       clk;
  logic       rst;
  logic       tick_in, start, stop, pause, mode;
  logic [3:0] len;

  logic       timeout, busy, paused;
  logic [3:0] remaining;
  logic [7:0] expiries;

  logic       s_timeout, s_busy, s_paused;
  logic [3:0] s_remaining;
  logic [1:0] s_expiries;

  int n_cmp = 0;
  int n_err = 0;

  timeout_timer #(.CNT_W(4), .DEFAULT_LEN(2), .EXP_W(8)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop),
    .pause(pause), .mode(mode), .len(len),
    .timeout(timeout), .busy(busy), .paused(paused),
    .remaining(remaining), .expiries(expiries)
  );

  timeout_timer #(.CNT_W(4), .DEFAULT_LEN(2), .EXP_W(2)) dut_sat (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop),
    .pause(pause), .mode(mode), .len(len),
    .timeout(s_timeout), .busy(s_busy), .paused(s_paused),
    .remaining(s_remaining), .expiries(s_expiries)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_main(input string tag, input logic t, input logic b, input logic p,
                          input logic [3:0] r, input logic [7:0] e);
    chk({tag, ".timeout"},   32'(timeout),   32'(t));
    chk({tag, ".busy"},      32'(busy),      32'(b));
    chk({tag, ".paused"},    32'(paused),    32'(p));
    chk({tag, ".remaining"}, 32'(remaining), 32'(r));
    chk({tag, ".expiries"},  32'(expiries),  32'(e));
  endtask

  task automatic chk_sat(input string tag, input logic t, input logic b,
                         input logic [3:0] r, input logic [1:0] e);
    chk({tag, ".timeout"},   32'(s_timeout),   32'(t));
    chk({tag, ".busy"},      32'(s_busy),      32'(b));
    chk({tag, ".remaining"}, 32'(s_remaining), 32'(r));
    chk({tag, ".expiries"},  32'(s_expiries),  32'(e));
  endtask

  task automatic do_start(input logic [3:0] l, input logic m);
    len = l; mode = m; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_tick();
    tick_in = 1'b1;
    cyc();
    tick_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick_in = 1'b0; start = 1'b0; stop = 1'b0;
    pause = 1'b0; mode = 1'b0; len = 4'd0;
    idle(2);
    chk_main("por", 0, 0, 0, 4'd0, 8'd0);
    rst = 1'b0;
    idle(1);

    // T2: one-shot with default length
    do_start(4'd0, 1'b0);
    chk_main("t2_start", 0, 1, 0, 4'd2, 8'd0);
    idle(9);
    do_tick();
    chk_main("t2_tick1", 0, 1, 0, 4'd1, 8'd0);
    idle(9);
    do_tick();
    chk_main("t2_tick2", 1, 0, 0, 4'd0, 8'd1);
    idle(1);
    chk_main("t2_after", 0, 0, 0, 4'd0, 8'd1);
    do_tick();
    chk_main("t2_idle_tick", 0, 0, 0, 4'd0, 8'd1);

    // T3: periodic, len 3, nine ticks
    do_start(4'd3, 1'b1);
    chk_main("t3_start", 0, 1, 0, 4'd3, 8'd0);
    do_tick(); chk_main("t3_k1", 0, 1, 0, 4'd2, 8'd0); idle(1);
    do_tick(); chk_main("t3_k2", 0, 1, 0, 4'd1, 8'd0); idle(1);
    do_tick(); chk_main("t3_k3", 1, 1, 0, 4'd3, 8'd1); idle(1);
    chk_main("t3_gap3", 0, 1, 0, 4'd3, 8'd1);
    do_tick(); chk_main("t3_k4", 0, 1, 0, 4'd2, 8'd1); idle(1);
    do_tick(); chk_main("t3_k5", 0, 1, 0, 4'd1, 8'd1); idle(1);
    do_tick(); chk_main("t3_k6", 1, 1, 0, 4'd3, 8'd2); idle(1);
    do_tick(); chk_main("t3_k7", 0, 1, 0, 4'd2, 8'd2); idle(1);
    do_tick(); chk_main("t3_k8", 0, 1, 0, 4'd1, 8'd2); idle(1);
    do_tick(); chk_main("t3_k9", 1, 1, 0, 4'd3, 8'd3); idle(1);
    chk_main("t3_end", 0, 1, 0, 4'd3, 8'd3);

    // T4: pause/resume, len 4 one-shot
    do_start(4'd4, 1'b0);
    chk_main("t4_start", 0, 1, 0, 4'd4, 8'd0);
    do_tick();
    chk_main("t4_tick1", 0, 1, 0, 4'd3, 8'd0);
    pause = 1'b1; tick_in = 1'b1;
    cyc();
    tick_in = 1'b0;
    chk_main("t4_pause_tick", 0, 1, 1, 4'd3, 8'd0);
    do_tick(); chk_main("t4_hold_t2", 0, 1, 1, 4'd3, 8'd0);
    do_tick(); chk_main("t4_hold_t3", 0, 1, 1, 4'd3, 8'd0);
    pause = 1'b0;
    cyc();
    chk_main("t4_resume", 0, 1, 0, 4'd3, 8'd0);
    do_tick(); chk_main("t4_r1", 0, 1, 0, 4'd2, 8'd0);
    do_tick(); chk_main("t4_r2", 0, 1, 0, 4'd1, 8'd0);
    do_tick(); chk_main("t4_r3", 1, 0, 0, 4'd0, 8'd1);

    // T5a: tick and stop together at remaining 1
    do_start(4'd2, 1'b0);
    do_tick();
    chk_main("t5a_pre", 0, 1, 0, 4'd1, 8'd0);
    tick_in = 1'b1; stop = 1'b1;
    cyc();
    tick_in = 1'b0; stop = 1'b0;
    chk_main("t5a_stop", 0, 0, 0, 4'd0, 8'd0);
    idle(1);
    chk_main("t5a_after", 0, 0, 0, 4'd0, 8'd0);

    // T5b: start and tick together
    len = 4'd5; mode = 1'b0; start = 1'b1; tick_in = 1'b1;
    cyc();
    start = 1'b0; tick_in = 1'b0;
    chk_main("t5b_start_tick", 0, 1, 0, 4'd5, 8'd0);

    // T5c: start and stop together
    len = 4'd7; start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk_main("t5c_start_stop", 0, 0, 0, 4'd0, 8'd0);

    // start with pause high goes straight to HOLD
    pause = 1'b1;
    do_start(4'd6, 1'b0);
    chk_main("start_in_hold", 0, 1, 1, 4'd6, 8'd0);
    pause = 1'b0;
    stop = 1'b1; cyc(); stop = 1'b0;

    // T1: reset mid-count
    do_start(4'd5, 1'b1);
    do_tick();
    do_tick();
    chk_main("t1_pre", 0, 1, 0, 4'd3, 8'd0);
    rst = 1'b1; tick_in = 1'b1;
    cyc();
    chk_main("t1_rst1", 0, 0, 0, 4'd0, 8'd0);
    cyc();
    rst = 1'b0;
    chk_main("t1_rst2", 0, 0, 0, 4'd0, 8'd0);
    cyc();
    tick_in = 1'b0;
    chk_main("t1_tick_after", 0, 0, 0, 4'd0, 8'd0);

    // T6: saturation on the 2-bit expiry instance, then restart mid-count
    do_start(4'd1, 1'b1);
    chk_sat("t6_start", 0, 1, 4'd1, 2'd0);
    do_tick(); chk_sat("t6_k1", 1, 1, 4'd1, 2'd1); idle(1);
    chk_sat("t6_gap", 0, 1, 4'd1, 2'd1);
    do_tick(); chk_sat("t6_k2", 1, 1, 4'd1, 2'd2); idle(1);
    do_tick(); chk_sat("t6_k3", 1, 1, 4'd1, 2'd3); idle(1);
    do_tick(); chk_sat("t6_k4", 1, 1, 4'd1, 2'd3); idle(1);
    do_tick(); chk_sat("t6_k5", 1, 1, 4'd1, 2'd3); idle(1);
    do_start(4'd4, 1'b0);
    chk_sat("t6_restart", 0, 1, 4'd4, 2'd0);
    do_tick();
    chk_sat("t6_mid", 0, 1, 4'd3, 2'd0);
    do_start(4'd6, 1'b0);
    chk_sat("t6_restart_mid", 0, 1, 4'd6, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
